// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   - MD_* op encodings as seen on the 3-bit op port
//   - md_state_e controller states
//   - default busy latencies and counter width
package muldiv_ctrl_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;
  localparam int unsigned MD_CNT_W           = 4;

endpackage

// File: rtl/muldiv_alu.sv
// Combinational arithmetic for the multiply/divide sequencer.
//   op          : MD_* operation code
//   a, b        : rs / rt operands
//   result      : {hi, lo} value; product for MULT/MULTU,
//                 {remainder, quotient} for DIV/DIVU, zero otherwise
//   div_by_zero : DIV/DIVU with b == 0 (result is then meaningless)
module muldiv_alu
  import muldiv_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               b_zero;
  logic               s_ovf;
  logic signed [31:0] s_divisor;
  logic signed [31:0] s_quot;
  logic signed [31:0] s_rem;
  logic        [31:0] u_divisor;
  logic        [31:0] u_quot;
  logic        [31:0] u_rem;

  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};

    b_zero = (b == '0);
    // 0x80000000 / -1 overflows; dividing by 1 instead yields the
    // architected result (quotient 0x80000000, remainder 0) and keeps
    // the divider free of the overflow and zero-divisor cases.
    s_ovf     = (a == 32'h8000_0000) && (b == '1);
    s_divisor = (b_zero || s_ovf) ? 32'sd1 : $signed(b);
    s_quot    = $signed(a) / s_divisor;
    s_rem     = $signed(a) % s_divisor;

    u_divisor = b_zero ? 32'd1 : b;
    u_quot    = a / u_divisor;
    u_rem     = a % u_divisor;

    result      = '0;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV: begin
        result      = {s_rem, s_quot};
        div_by_zero = b_zero;
      end
      MD_DIVU: begin
        result      = {u_rem, u_quot};
        div_by_zero = b_zero;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer owning HI/LO.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : valid MULT/MULTU/DIV/DIVU/MTHI/MTLO in EX this cycle
//   op         : MD_* operation code (6-7 are NOPs)
//   a, b       : rs / rt operands
//   flush      : cancels a start in the same cycle
//   busy       : fixed-latency operation in progress
//   hi, lo     : architectural HI/LO registers
//   done       : one-cycle pulse after HI/LO take a mult/div result
// The result is computed at the accepting edge and held in a pending
// register; busy emulates the unit latency before HI/LO are updated.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]         pend_q, pend_d;
  logic                pend_dbz_q, pend_dbz_d;
  logic [31:0]         hi_q, hi_d;
  logic [31:0]         lo_q, lo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [63:0]         alu_result;
  logic                alu_dbz;
  logic                accept;

  muldiv_alu u_alu (
    .op          (op),
    .a           (a),
    .b           (b),
    .result      (alu_result),
    .div_by_zero (alu_dbz)
  );

  assign accept = start && !flush && (state_q == ST_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_dbz_d = pend_dbz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              pend_d     = alu_result;
              pend_dbz_d = 1'b0;
              cnt_d      = MULT_LOAD;
              state_d    = ST_MUL;
              busy_d     = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              pend_d     = alu_result;
              pend_dbz_d = alu_dbz;
              cnt_d      = DIV_LOAD;
              state_d    = ST_DIV;
              busy_d     = 1'b1;
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == MD_CNT_W'(1)) begin
          if (!pend_dbz_q) begin
            {hi_d, lo_d} = pend_q;
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - MD_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_dbz_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_dbz_q <= pend_dbz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed and random operations
// compared against an arithmetic reference model of HI/LO and timing.
module tb_muldiv_ctrl;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;
  localparam int          WIN    = 20;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stall logic must never issue a live start while the unit is busy.
  always @(posedge clk) begin
    if (rst_n && start && !flush) begin
      assert (busy === 1'b0) else begin
        errors++;
        $error("FAIL start_while_busy: busy=%b required 0", busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // Reference model: updates m_hi/m_lo and returns expected busy length
  // and whether done pulses.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit acc, output int n, output bit dn);
    longint          p, q, r;
    longint unsigned pu, qu, ru;
    n  = 0;
    dn = 1'b0;
    if (!acc) return;
    case (o)
      3'd0: begin
        p = longint'($signed(x)) * longint'($signed(y));
        {m_hi, m_lo} = p;
        n = MULT_N; dn = 1'b1;
      end
      3'd1: begin
        pu = longint'({32'd0, x}) * longint'({32'd0, y});
        {m_hi, m_lo} = pu;
        n = MULT_N; dn = 1'b1;
      end
      3'd2: begin
        if (y != 0) begin
          q = longint'($signed(x)) / longint'($signed(y));
          r = longint'($signed(x)) % longint'($signed(y));
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
        n = DIV_N; dn = 1'b1;
      end
      3'd3: begin
        if (y != 0) begin
          qu = longint'({32'd0, x}) / longint'({32'd0, y});
          ru = longint'({32'd0, x}) % longint'({32'd0, y});
          m_lo = qu[31:0];
          m_hi = ru[31:0];
        end
        n = DIV_N; dn = 1'b1;
      end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
  endtask

  // Issue one start, then watch WIN cycles of busy/done and check HI/LO.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input bit fl, input int flush_at);
    logic [WIN-1:0] bv, dv, exp_bv, exp_dv, one;
    logic [31:0]    old_hi, old_lo, mid_hi, mid_lo;
    int             n;
    bit             dn;
    old_hi = m_hi;
    old_lo = m_lo;
    mid_hi = m_hi;
    mid_lo = m_lo;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; flush = fl;
    model(o, x, y, !fl, n, dn);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    bv = '0; dv = '0;
    for (int i = 0; i < WIN; i++) begin
      bv[i] = busy;
      dv[i] = done;
      if (n > 0 && i == n - 1) begin
        mid_hi = hi;
        mid_lo = lo;
      end
      flush = (i == flush_at);
      @(negedge clk);
    end
    flush = 1'b0;
    one    = 1;
    exp_bv = (one << n) - one;
    exp_dv = dn ? (one << n) : '0;
    chk({tag, ".busy"}, 64'(bv), 64'(exp_bv));
    chk({tag, ".done"}, 64'(dv), 64'(exp_dv));
    chk({tag, ".hi"}, 64'(hi), 64'(m_hi));
    chk({tag, ".lo"}, 64'(lo), 64'(m_lo));
    if (dn) begin
      chk({tag, ".hi_held"}, 64'(mid_hi), 64'(old_hi));
      chk({tag, ".lo_held"}, 64'(mid_lo), 64'(old_lo));
    end
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    bit          rf;
    int          rfa;
    int unsigned sel;
    bit          saw_done;

    rst_n = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset.busy", 64'(busy), 64'(0));
    chk("reset.done", 64'(done), 64'(0));
    chk("reset.hi", 64'(hi), 64'(0));
    chk("reset.lo", 64'(lo), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, -1);
    chk("mult_neg.hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    chk("mult_neg.lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFA);
    do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
    chk("multu_max.hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    chk("multu_max.lo_const", 64'(lo), 64'h0000_0000_0000_0001);
    do_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    chk("div_neg.lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    chk("div_neg.hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    do_op("divu_zero", 3'd3, 32'h1234_0000, 32'd0, 1'b0, -1);
    do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
    chk("div_ovf.lo_const", 64'(lo), 64'h0000_0000_8000_0000);
    chk("div_ovf.hi_const", 64'(hi), 64'h0);

    // MTHI then MTLO on consecutive cycles.
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h1234_5678; flush = 1'b0;
    @(negedge clk);
    chk("mthi.hi", 64'(hi), 64'h0000_0000_1234_5678);
    chk("mthi.busy", 64'(busy), 64'(0));
    op = 3'd5; a = 32'h9;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo.lo", 64'(lo), 64'h9);
    chk("mtlo.busy", 64'(busy), 64'(0));
    chk("mtlo.done", 64'(done), 64'(0));
    m_hi = 32'h1234_5678;
    m_lo = 32'h9;

    do_op("mult_flushed", 3'd0, 32'd7, 32'd9, 1'b1, -1);
    do_op("div_midflush", 3'd2, 32'd100, 32'd7, 1'b0, 4);
    do_op("reserved", 3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0, -1);

    // Asynchronous reset in the third busy cycle of a MULT.
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd11; b = 32'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", 64'(busy), 64'(0));
    chk("arst.hi", 64'(hi), 64'(0));
    chk("arst.lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("arst.no_done", 64'(saw_done), 64'(0));
    chk("arst.hi_after", 64'(hi), 64'(0));

    for (int k = 0; k < 40; k++) begin
      ro  = 3'($urandom_range(0, 7));
      rx  = $urandom;
      sel = $urandom_range(0, 7);
      ry  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? 32'd1 : $urandom;
      if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
      rf  = ($urandom_range(0, 7) == 0);
      rfa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
      do_op($sformatf("rnd%0d_op%0d", k, ro), ro, rx, ry, rf, rfa);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
